dp_rr_scheduler: RTL and testbench
==================================

# dp_rr_scheduler

Round-robin scheduler that shares one instance of the two-stage A/B/C/D→Z datapath (combinational stage, one register stage, combinational stage) among several requesters. It sits directly in front of the datapath and drives its A, B, C and D inputs. It tags every issued operand so that the datapath's Z output is returned to the requester that owns it. A drain handshake lets the system quiesce the datapath, for example before pulsing the datapath's own synchronous reset.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- LATENCY, 1, register stages between datapath inputs and Z; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock; one clock domain.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  bit i: requester i offers an operand.
- req_data  in  4*NUM_REQ  operand of requester i, packed as bits [4i+3:4i], with A=bit 4i, B=4i+1, C=4i+2, D=4i+3.
- req_ready  out  NUM_REQ  one-hot or zero; bit i high when requester i wins this cycle.
- dp_a, dp_b, dp_c, dp_d  out  1 each  registered operand driven into the datapath.
- dp_z  in  1  datapath result.
- rsp_valid  out  1  registered; response present this cycle. There is no backpressure, so the consumer must accept it.
- rsp_id  out  clog2(NUM_REQ)  owner of the response.
- rsp_z  out  1  captured dp_z.
- drain_req  in  1  level; requests quiesce.
- halted  out  1  registered; high in HALT.

## Operation
- Transfer rule: an operand transfers when req_valid[i] and req_ready[i] are both high in the same cycle.
- req_ready is combinational from req_valid, the priority pointer and the state. It never depends on req_data.
- Arbitration:
  - Priority starts at the pointer and descends cyclically: ptr, ptr+1, …, NUM_REQ-1, 0, ….
  - After a grant to requester i, ptr becomes i+1, wrapping from NUM_REQ-1 to 0.
  - With no grant, ptr holds.
  - ptr resets to 0.
- Issue register:
  - On a transfer, dp_a..dp_d load the winner's operand.
  - With no transfer, dp_a..dp_d load 0.
  - The tag pipeline (valid, id), LATENCY+1 stages deep, shifts every cycle.
- Response: rsp_valid, rsp_id and rsp_z load from the last tag stage and dp_z. When the last stage is invalid, rsp_valid=0, rsp_id holds and rsp_z holds.
- State machine, three states:
  - RUN: grants are enabled.
    - drain_req=1 → DRAIN. No grant is issued in that same cycle; drain wins over any request.
  - DRAIN: no grants.
    - Once every tag stage is invalid → HALT.
    - In-flight operands always complete and produce responses.
    - drain_req falling in DRAIN does not abort the drain; the drain still completes to HALT.
  - HALT: no grants; halted=1.
    - drain_req=0 → RUN. Grants resume in the first RUN cycle.
- Reset values:
  - State RUN, ptr 0, all tag stages invalid.
  - dp_a..dp_d = 0, rsp_valid = 0, rsp_id = 0, rsp_z = 0, halted = 0.
  - req_ready = 0 while rst is high.
- Reset mid-operation: all in-flight tags are discarded and no response is produced for them. Outputs take reset values asynchronously.

## Timing
- Handshake in cycle n → dp_* carry the operand in cycle n+1 → dp_z is valid in cycle n+1+LATENCY → rsp_valid in cycle n+2+LATENCY. With LATENCY=1, the response arrives 3 cycles after the handshake.
- Throughput: one issue per cycle in RUN. Responses return in issue order.
- Drain:
  - drain_req rises in cycle d → state is DRAIN from d+1.
  - halted rises one cycle after the last in-flight response's rsp_valid cycle.
  - With nothing in flight, halted rises at d+2.
- Release: drain_req falls in cycle h → state is RUN from h+1, and req_ready can assert in h+1.

## Structure
- The shared package holds:
  - the state enum (RUN, DRAIN, HALT);
  - the constant OPW=4 and the operand bit positions A=0, B=1, C=2, D=3;
  - the id-width function.
- Sub-module rr_arbiter: parameter NUM_REQ; inputs req, enable and ptr; outputs the one-hot grant and the next ptr. The top level holds the FSM, issue register, tag pipeline and response register.

## Test plan
- Single requester: req_valid=0001, data=0xA, continuous for 5 cycles → req_ready[0]=1 every cycle. dp_{a,b,c,d}=0,1,0,1 from the cycle after the first handshake. Five responses with rsp_id=0, the first at handshake cycle+3.
- All four valid continuously → grant order 0,1,2,3,0,1. rsp_id follows the same order with 3-cycle latency.
- ptr=3 and only requesters 0 and 3 valid → grant 3, then 0, then 3. Checks wrap from 3 to 0.
- drain_req raised while 2 operands are in flight and all requesters valid → no further req_ready. Both responses delivered. halted=1 one cycle after the second rsp_valid. drain_req dropped → grants resume the next cycle.
- rst pulsed while 2 operands are in flight → rsp_valid=0, dp_* and rsp_* at 0 immediately. No stale response after rst falls. First grant after reset goes to requester 0.
- LATENCY=2 build, with a 2-register model of the datapath → responses at handshake cycle+4, with rsp_z matching the model.

Source files
------------

// File: rtl/dp_rr_scheduler_pkg.sv
// Shared types and constants for the round-robin datapath scheduler.
// Operand bit positions follow the datapath's A/B/C/D input order.
package dp_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam int OPW  = 4;
  localparam int OP_A = 0;
  localparam int OP_B = 1;
  localparam int OP_C = 2;
  localparam int OP_D = 3;

  function automatic int id_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/dp_rr_scheduler_rr_arbiter.sv
// Rotating-priority arbiter: searches from ptr upward with wrap and
// returns a one-hot grant plus the pointer that follows the winner.
module rr_arbiter
  import dp_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      next_ptr
);

  logic [IW-1:0] idx;
  logic          found;
  logic          take;

  // First requester at or after ptr (cyclically) wins
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = '0;
    take     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx  = IW'((int'(ptr) + k) % NUM_REQ);
      take = enable && !found && req[idx];
      grant[idx] = grant[idx] | take;
      if (take) begin
        next_ptr = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + IW'(1);
      end else begin
        next_ptr = next_ptr;
      end
      found = found | take;
    end
  end

endmodule

// File: rtl/dp_rr_scheduler.sv
// Round-robin front end for the shared A/B/C/D->Z datapath: issues one
// operand per cycle, tags it, and routes Z back to the owner; supports drain.
module dp_rr_scheduler
  import dp_rr_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [OPW*NUM_REQ-1:0]        req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          dp_a,
  output logic                          dp_b,
  output logic                          dp_c,
  output logic                          dp_d,
  input  logic                          dp_z,
  output logic                          rsp_valid,
  output logic [id_width(NUM_REQ)-1:0]  rsp_id,
  output logic                          rsp_z,
  input  logic                          drain_req,
  output logic                          halted
);

  localparam int IW = id_width(NUM_REQ);

  state_e             state_r;
  state_e             state_next_s;
  logic [IW-1:0]      ptr_r;
  logic [IW-1:0]      ptr_next_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               grant_en_s;
  logic [IW-1:0]      win_id_s;
  logic [OPW-1:0]     win_op_s;
  logic [LATENCY:0]   tag_valid_r;
  logic [IW-1:0]      tag_id_r [LATENCY+1];

  // Drain request blocks grants in the very cycle it is seen
  assign grant_en_s = (state_r == ST_RUN) && !drain_req && !rst;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req      (req_valid),
    .enable   (grant_en_s),
    .ptr      (ptr_r),
    .grant    (grant_s),
    .next_ptr (ptr_next_s)
  );

  assign req_ready = grant_s;

  // Winner id and operand; grant is one-hot so OR-reduction selects it
  always_comb begin
    win_id_s = '0;
    win_op_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_id_s = win_id_s | ({IW{grant_s[i]}} & IW'(i));
      win_op_s = win_op_s | ({OPW{grant_s[i]}} & req_data[OPW*i +: OPW]);
    end
  end

  // Next-state logic for RUN/DRAIN/HALT
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (drain_req) state_next_s = ST_DRAIN;
        else           state_next_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (tag_valid_r == '0) state_next_s = ST_HALT;
        else                   state_next_s = ST_DRAIN;
      end
      ST_HALT: begin
        if (!drain_req) state_next_s = ST_RUN;
        else            state_next_s = ST_HALT;
      end
      default: state_next_s = ST_RUN;
    endcase
  end

  // State, priority pointer and halted flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_RUN;
      ptr_r   <= '0;
      halted  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      ptr_r   <= ptr_next_s;
      halted  <= (state_next_s == ST_HALT);
    end
  end

  // Issue register and tag pipeline aligned with the datapath latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_a        <= 1'b0;
      dp_b        <= 1'b0;
      dp_c        <= 1'b0;
      dp_d        <= 1'b0;
      tag_valid_r <= '0;
      for (int k = 0; k <= LATENCY; k++) tag_id_r[k] <= '0;
    end else begin
      dp_a        <= win_op_s[OP_A];
      dp_b        <= win_op_s[OP_B];
      dp_c        <= win_op_s[OP_C];
      dp_d        <= win_op_s[OP_D];
      tag_valid_r <= {tag_valid_r[LATENCY-1:0], |grant_s};
      tag_id_r[0] <= win_id_s;
      for (int k = 1; k <= LATENCY; k++) tag_id_r[k] <= tag_id_r[k-1];
    end
  end

  // Response capture; id and z hold when no response is present
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_z     <= 1'b0;
    end else if (tag_valid_r[LATENCY]) begin
      rsp_valid <= 1'b1;
      rsp_id    <= tag_id_r[LATENCY];
      rsp_z     <= dp_z;
    end else begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dp_rr_scheduler.sv
// Directed bench for dp_rr_scheduler: LATENCY=1 and LATENCY=2 instances,
// each driving a small behavioral datapath model.
module tb_dp_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_valid2, req_ready2;
  logic [15:0] req_data, req_data2;
  logic        dp_a, dp_b, dp_c, dp_d, dp_z;
  logic        dp_a2, dp_b2, dp_c2, dp_d2, dp_z2;
  logic        rsp_valid, rsp_z, rsp_valid2, rsp_z2;
  logic [1:0]  rsp_id, rsp_id2;
  logic        drain_req, halted, halted2;
  logic        p1, q1, q2;
  int          checks = 0;
  int          errors = 0;

  typedef struct packed {
    logic [3:0]  v;
    logic [15:0] data;
    logic [3:0]  rdy;
    logic [3:0]  dp;
    logic        rv;
    logic [1:0]  rid;
    logic        rz;
  } vec_t;

  vec_t vecs [19];

  always #5 clk = ~clk;

  function automatic logic fz(input logic a, input logic b, input logic c, input logic d);
    return (a & b) | (c ^ d);
  endfunction

  // Datapath models: one register stage and two register stages
  always @(posedge clk) begin
    p1 <= fz(dp_a, dp_b, dp_c, dp_d);
    q1 <= fz(dp_a2, dp_b2, dp_c2, dp_d2);
    q2 <= q1;
  end
  assign dp_z  = p1;
  assign dp_z2 = q2;

  dp_rr_scheduler #(.NUM_REQ(4), .LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .dp_a(dp_a), .dp_b(dp_b), .dp_c(dp_c), .dp_d(dp_d),
    .dp_z(dp_z), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_z(rsp_z),
    .drain_req(drain_req), .halted(halted)
  );

  dp_rr_scheduler #(.NUM_REQ(4), .LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2),
    .req_ready(req_ready2), .dp_a(dp_a2), .dp_b(dp_b2), .dp_c(dp_c2), .dp_d(dp_d2),
    .dp_z(dp_z2), .rsp_valid(rsp_valid2), .rsp_id(rsp_id2), .rsp_z(rsp_z2),
    .drain_req(1'b0), .halted(halted2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One cycle on the LATENCY=1 instance: drive, check at negedge, advance
  task automatic cyc(input string tag, input logic [3:0] v, input logic dr,
                     input logic [3:0] e_rdy, input logic e_rv, input logic [1:0] e_rid,
                     input logic e_rz, input logic e_halt);
    req_valid = v;
    drain_req = dr;
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(req_ready), 32'(e_rdy));
    chk({tag, "_rv"}, 32'(rsp_valid), 32'(e_rv));
    chk({tag, "_halt"}, 32'(halted), 32'(e_halt));
    if (e_rv) begin
      chk({tag, "_rid"}, 32'(rsp_id), 32'(e_rid));
      chk({tag, "_rz"}, 32'(rsp_z), 32'(e_rz));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{4'hF, 16'hC053, 4'h1, 4'h0, 1'b0, 2'd0, 1'b0};
    vecs[1]  = '{4'hF, 16'hC053, 4'h2, 4'h3, 1'b0, 2'd0, 1'b0};
    vecs[2]  = '{4'hF, 16'hC053, 4'h4, 4'h5, 1'b0, 2'd0, 1'b0};
    vecs[3]  = '{4'hF, 16'hC053, 4'h8, 4'h0, 1'b1, 2'd0, 1'b1};
    vecs[4]  = '{4'hF, 16'hC053, 4'h1, 4'hC, 1'b1, 2'd1, 1'b1};
    vecs[5]  = '{4'hF, 16'hC053, 4'h2, 4'h3, 1'b1, 2'd2, 1'b0};
    vecs[6]  = '{4'h4, 16'hC053, 4'h4, 4'h5, 1'b1, 2'd3, 1'b0};
    vecs[7]  = '{4'h9, 16'hC053, 4'h8, 4'h0, 1'b1, 2'd0, 1'b1};
    vecs[8]  = '{4'h9, 16'hC053, 4'h1, 4'hC, 1'b1, 2'd1, 1'b1};
    vecs[9]  = '{4'h9, 16'hC053, 4'h8, 4'h3, 1'b1, 2'd2, 1'b0};
    vecs[10] = '{4'h1, 16'hC05A, 4'h1, 4'hC, 1'b1, 2'd3, 1'b0};
    vecs[11] = '{4'h1, 16'hC05A, 4'h1, 4'hA, 1'b1, 2'd0, 1'b1};
    vecs[12] = '{4'h1, 16'hC05A, 4'h1, 4'hA, 1'b1, 2'd3, 1'b0};
    vecs[13] = '{4'h1, 16'hC05A, 4'h1, 4'hA, 1'b1, 2'd0, 1'b1};
    vecs[14] = '{4'h1, 16'hC05A, 4'h1, 4'hA, 1'b1, 2'd0, 1'b1};
    vecs[15] = '{4'h0, 16'hC05A, 4'h0, 4'hA, 1'b1, 2'd0, 1'b1};
    vecs[16] = '{4'h0, 16'hC05A, 4'h0, 4'h0, 1'b1, 2'd0, 1'b1};
    vecs[17] = '{4'h0, 16'hC05A, 4'h0, 4'h0, 1'b1, 2'd0, 1'b1};
    vecs[18] = '{4'h0, 16'hC05A, 4'h0, 4'h0, 1'b0, 2'd0, 1'b1};

    rst = 1'b1;
    req_valid = 4'hF;
    req_data = 16'hC053;
    drain_req = 1'b0;
    req_valid2 = 4'h3;
    req_data2 = 16'h0003;

    // Reset state, including req_ready held low under reset
    @(negedge clk);
    chk("rst_rdy", 32'(req_ready), 32'h0);
    chk("rst_rdy2", 32'(req_ready2), 32'h0);
    chk("rst_outs", 32'({dp_d, dp_c, dp_b, dp_a, rsp_valid, rsp_id, rsp_z, halted}), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = 4'h0;

    // LATENCY=2 instance: grants 0 then 1, responses 4 cycles after handshake
    for (int e = 0; e < 7; e++) begin
      if (e >= 2) req_valid2 = 4'h0;
      @(negedge clk);
      chk($sformatf("l2_e%0d_rdy", e), 32'(req_ready2),
          (e == 0) ? 32'h1 : ((e == 1) ? 32'h2 : 32'h0));
      chk($sformatf("l2_e%0d_rv", e), 32'(rsp_valid2), (e == 4 || e == 5) ? 32'h1 : 32'h0);
      if (e == 1) chk("l2_dp", 32'({dp_d2, dp_c2, dp_b2, dp_a2}), 32'h3);
      if (e == 4) chk("l2_rsp0", 32'({rsp_id2, rsp_z2}), 32'h1);
      if (e == 5) chk("l2_rsp1", 32'({rsp_id2, rsp_z2}), 32'h2);
      @(posedge clk);
      #1;
    end

    // Table: all-valid rotation, wrap 3->0, then single requester stream
    for (int i = 0; i < 19; i++) begin
      req_valid = vecs[i].v;
      req_data = vecs[i].data;
      @(negedge clk);
      chk($sformatf("vec%0d_rdy", i), 32'(req_ready), 32'(vecs[i].rdy));
      chk($sformatf("vec%0d_dp", i), 32'({dp_d, dp_c, dp_b, dp_a}), 32'(vecs[i].dp));
      chk($sformatf("vec%0d_rsp", i), 32'({rsp_valid, rsp_id, rsp_z}),
          32'({vecs[i].rv, vecs[i].rid, vecs[i].rz}));
      chk($sformatf("vec%0d_halt", i), 32'(halted), 32'h0);
      @(posedge clk);
      #1;
    end

    // Drain with two operands in flight, then release
    req_data = 16'hC053;
    cyc("d0", 4'hF, 1'b0, 4'h2, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("d1", 4'hF, 1'b0, 4'h4, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("d2", 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("d3", 4'hF, 1'b1, 4'h0, 1'b1, 2'd1, 1'b1, 1'b0);
    cyc("d4", 4'hF, 1'b1, 4'h0, 1'b1, 2'd2, 1'b0, 1'b0);
    cyc("d5", 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc("d6", 4'hF, 1'b1, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc("d7", 4'hF, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b1);
    cyc("d8", 4'hF, 1'b0, 4'h8, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("d9", 4'hF, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset with two operands in flight
    rst = 1'b1;
    #1;
    chk("arst_outs", 32'({dp_d, dp_c, dp_b, dp_a, rsp_valid, rsp_id, rsp_z, halted}), 32'h0);
    chk("arst_rdy", 32'(req_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("r0", 4'hF, 1'b0, 4'h1, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("r1", 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("r2", 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc("r3", 4'h0, 1'b0, 4'h0, 1'b1, 2'd0, 1'b1, 1'b0);
    cyc("r4", 4'h0, 1'b0, 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
